// File: rtl/data_mem_ctrl.sv
// Data-memory controller: valid/ready requests, byte/half/word RAM access with
// extension and misalignment checks, plus an MMIO window for LEDR/HEX/SW/KEY.
//
// state  | meaning
// IDLE   | ready for a request; errors, stores and MMIO are resolved here
// RAM_RD | synchronous RAM read of a registered load
// RESP   | response pulse on rsp_valid, then back to IDLE
module data_mem_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int RAM_WORDS = 2 ** (ADDR_W - 3),
  parameter int NUM_HEX   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  input  logic [9:0]           sw,
  input  logic [3:0]           key,
  output logic [9:0]           ledr,
  output logic [7*NUM_HEX-1:0] hex
);

  localparam int RI_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RAM_RD, RESP} state_t;

  state_t           state;
  logic [31:0]      mem [RAM_WORDS];
  logic [9:0]       sw_m, sw_s;
  logic [3:0]       key_m, key_s;
  logic             accept, is_mmio, map_hit, err;
  logic [31:0]      off, mmio_rdata, wdata_rep;
  logic [3:0]       be;
  logic [RI_W-1:0]  ram_idx, ld_idx;
  logic [1:0]       ld_lo, ld_size;
  logic             ld_uns;

  assign accept  = req_valid && req_ready;
  assign is_mmio = req_addr[ADDR_W-1];
  assign off     = 32'(req_addr[ADDR_W-2:0]);
  assign ram_idx = RI_W'(32'(req_addr[ADDR_W-2:2]) % RAM_WORDS);

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = word >> {lo, 3'b000};
    case (size)
      2'd0:    load_extract = uns ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
      2'd1:    load_extract = uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_extract = s;
    endcase
  endfunction

  always_comb begin
    map_hit    = (off == 32'h0) || (off == 32'h40) || (off == 32'h44);
    mmio_rdata = 32'b0;
    if (off == 32'h0)  mmio_rdata = {22'b0, ledr};
    if (off == 32'h40) mmio_rdata = {22'b0, sw_s};
    if (off == 32'h44) mmio_rdata = {28'b0, key_s};
    for (int i = 0; i < NUM_HEX; i++) begin
      if (off == 32'(4 + 4 * i)) begin
        map_hit    = 1'b1;
        mmio_rdata = {25'b0, hex[7*i +: 7]};
      end
    end
    err = (req_size == 2'd3) ||
          (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
          (is_mmio && (req_size != 2'd2 || !map_hit));
    case (req_size)
      2'd0: begin
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be        = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // RAM kept out of the reset domain so its contents survive rst
  always_ff @(posedge clk) begin
    if (!rst && accept && req_write && !err && !is_mmio) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[ram_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'b0;
      rsp_err   <= 1'b0;
      ledr      <= 10'b0;
      hex       <= {NUM_HEX{7'h7F}};
      sw_m      <= 10'b0;
      sw_s      <= 10'b0;
      key_m     <= 4'b0;
      key_s     <= 4'b0;
      ld_idx    <= '0;
      ld_lo     <= 2'b0;
      ld_size   <= 2'b0;
      ld_uns    <= 1'b0;
    end else begin
      sw_m  <= sw;
      sw_s  <= sw_m;
      key_m <= key;
      key_s <= key_m;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            rsp_rdata <= 32'b0;
            rsp_err   <= err;
            if (err || is_mmio || req_write) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              if (!err && is_mmio) begin
                if (!req_write) begin
                  rsp_rdata <= mmio_rdata;
                end else begin
                  if (off == 32'h0) ledr <= req_wdata[9:0];
                  for (int i = 0; i < NUM_HEX; i++)
                    if (off == 32'(4 + 4 * i)) hex[7*i +: 7] <= req_wdata[6:0];
                end
              end
            end else begin
              state   <= RAM_RD;
              ld_idx  <= ram_idx;
              ld_lo   <= req_addr[1:0];
              ld_size <= req_size;
              ld_uns  <= req_unsigned;
            end
          end
        end
        RAM_RD: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= load_extract(mem[ld_idx], ld_lo, ld_size, ld_uns);
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'b0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
